// File: rtl/fetch_unit_pkg.sv
// ============================================================================
// Module  : fetch_unit_pkg
// Purpose : Shared jump-kind encodings, nop constant and fetch-address window
//           for the fetch stage.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

package fetch_unit_pkg;

    typedef enum logic [1:0] {
        JSEL_NONE = 2'b00,
        JSEL_J    = 2'b01,
        JSEL_JR   = 2'b10,
        JSEL_RSVD = 2'b11
    } jsel_e;

    localparam logic [31:0] C_NOP_INSTR    = 32'h0000_0000;
    localparam logic [31:0] C_FETCH_ADDR_LO = 32'h0000_3000;
    localparam logic [31:0] C_FETCH_ADDR_HI = 32'h0000_6FFC;

endpackage

`default_nettype wire

// File: rtl/fetch_unit_npc.sv
// ============================================================================
// Module  : npc
// Purpose : Next-PC selection, priority jr > j > taken branch > sequential.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module npc
    import fetch_unit_pkg::*;
(
    input  logic [31:0] f_pc_i,
    input  logic [31:0] d_pc_i,
    input  logic [25:0] d_instr_idx_i,
    input  logic        d_is_branch_i,
    input  jsel_e       d_jsel_i,
    input  logic [31:0] d_rd1_i,
    output logic [31:0] npc_o
);

    logic [31:0] w_seq;
    logic [31:0] w_br;
    logic [31:0] w_jmp;

    always_comb begin
        w_seq = f_pc_i + 32'd4;
        // Branch offset is relative to the delay-slot address, wrapping mod 2^32.
        w_br  = d_pc_i + 32'd4 + {{14{d_instr_idx_i[15]}}, d_instr_idx_i[15:0], 2'b00};
        w_jmp = {d_pc_i[31:28], d_instr_idx_i, 2'b00};

        if (d_jsel_i == JSEL_JR) begin
            npc_o = d_rd1_i;
        end else if (d_jsel_i == JSEL_J) begin
            npc_o = w_jmp;
        end else if (d_is_branch_i) begin
            npc_o = w_br;
        end else begin
            npc_o = w_seq;
        end
    end

endmodule

`default_nettype wire

// File: rtl/fetch_unit.sv
// ============================================================================
// Module  : fetch_unit
// Purpose : PC register and F/D pipeline register with one-delay-slot redirect.
//           Optional macro FETCH_ADDR_CHECK_EN adds the D_excAdEL fetch check.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        D_isBranch,
    input  logic        D_flush,
    input  logic [1:0]  D_jSel,
    input  logic [31:0] D_RD1,
    input  logic [31:0] F_Instr,
    output logic [31:0] F_PC,
    output logic [31:0] D_Instr,
    output logic [31:0] D_PC
`ifdef FETCH_ADDR_CHECK_EN
    ,
    output logic        D_excAdEL
`endif
);

    logic [31:0] pc_q,    pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] dpc_q,   dpc_d;
    logic [31:0] w_npc;
    logic        w_bad_addr;

    npc u_npc (
        .f_pc_i        (pc_q),
        .d_pc_i        (dpc_q),
        .d_instr_idx_i (instr_q[25:0]),
        .d_is_branch_i (D_isBranch),
        .d_jsel_i      (jsel_e'(D_jSel)),
        .d_rd1_i       (D_RD1),
        .npc_o         (w_npc)
    );

`ifdef FETCH_ADDR_CHECK_EN
    logic exc_q, exc_d;

    assign w_bad_addr = (pc_q[1:0] != 2'b00) || (pc_q < C_FETCH_ADDR_LO) || (pc_q > C_FETCH_ADDR_HI);
`else
    assign w_bad_addr = 1'b0;
`endif

    always_comb begin
        pc_d    = pc_q;
        instr_d = instr_q;
        dpc_d   = dpc_q;
        if (!stall) begin
            pc_d  = w_npc;
            dpc_d = pc_q;
            // Annul and bad fetch both replace the captured word with a nop.
            instr_d = (D_flush || w_bad_addr) ? C_NOP_INSTR : F_Instr;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q    <= RESET_PC;
            instr_q <= 32'h0000_0000;
            dpc_q   <= 32'h0000_0000;
        end else begin
            pc_q    <= pc_d;
            instr_q <= instr_d;
            dpc_q   <= dpc_d;
        end
    end

`ifdef FETCH_ADDR_CHECK_EN
    always_comb begin
        exc_d = exc_q;
        if (!stall) begin
            exc_d = w_bad_addr && !D_flush;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            exc_q <= 1'b0;
        end else begin
            exc_q <= exc_d;
        end
    end

    assign D_excAdEL = exc_q;
`endif

    assign F_PC    = pc_q;
    assign D_Instr = instr_q;
    assign D_PC    = dpc_q;

endmodule

`default_nettype wire

// File: tb/tb_fetch_unit.sv
// ============================================================================
// Module  : tb_fetch_unit
// Purpose : Directed self-checking bench for fetch_unit (FETCH_ADDR_CHECK_EN
//           cases included when the macro is defined).
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module tb_fetch_unit;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        D_isBranch;
    logic        D_flush;
    logic [1:0]  D_jSel;
    logic [31:0] D_RD1;
    logic [31:0] F_Instr;
    logic [31:0] F_PC;
    logic [31:0] D_Instr;
    logic [31:0] D_PC;
    logic        use_ovr;
    logic [31:0] ovr_instr;
`ifdef FETCH_ADDR_CHECK_EN
    logic        D_excAdEL;
`endif

    int n_chk;
    int n_bad;

    fetch_unit #(.RESET_PC(32'h0000_3000)) dut (
        .clk        (clk),
        .reset      (reset),
        .stall      (stall),
        .D_isBranch (D_isBranch),
        .D_flush    (D_flush),
        .D_jSel     (D_jSel),
        .D_RD1      (D_RD1),
        .F_Instr    (F_Instr),
        .F_PC       (F_PC),
        .D_Instr    (D_Instr),
        .D_PC       (D_PC)
`ifdef FETCH_ADDR_CHECK_EN
        ,
        .D_excAdEL  (D_excAdEL)
`endif
    );

    // Instruction memory model: a recognisable word derived from the address.
    assign F_Instr = use_ovr ? ovr_instr : {16'hC0DE, F_PC[15:0]};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%08h exp=%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_chk = 0;
        n_bad = 0;
        reset = 1'b1; stall = 1'b0; D_isBranch = 1'b0; D_flush = 1'b0;
        D_jSel = 2'b00; D_RD1 = 32'h0; use_ovr = 1'b0; ovr_instr = 32'h0;

        #2;
        chk("rst_fpc",   F_PC,    32'h0000_3000);
        chk("rst_dinst", D_Instr, 32'h0);
        chk("rst_dpc",   D_PC,    32'h0);
        reset = 1'b0;

        step();
        chk("seq_fpc",   F_PC,    32'h0000_3004);
        chk("seq_dpc",   D_PC,    32'h0000_3000);
        chk("seq_dinst", D_Instr, 32'hC0DE_3000);
        step();

        // Taken branch back by two words from D_PC=0x3008.
        use_ovr = 1'b1; ovr_instr = 32'h1000_FFFE;
        step();
        chk("br_dpc",  D_PC, 32'h0000_3008);
        chk("br_fpc0", F_PC, 32'h0000_300C);
        use_ovr = 1'b0; D_isBranch = 1'b1;
        step();
        D_isBranch = 1'b0;
        chk("br_target", F_PC,    32'h0000_3004);
        chk("br_slot_pc", D_PC,   32'h0000_300C);
        chk("br_slot_in", D_Instr, 32'hC0DE_300C);

        step(); step(); step();
        chk("ann_pre", F_PC, 32'h0000_3010);
        D_flush = 1'b1;
        step();
        D_flush = 1'b0;
        chk("ann_dinst", D_Instr, 32'h0);
        chk("ann_dpc",   D_PC,    32'h0000_3010);
        chk("ann_fpc",   F_PC,    32'h0000_3014);

        step();
        stall = 1'b1; D_flush = 1'b1; D_jSel = 2'b10; D_RD1 = 32'h0000_5000;
        for (int i = 0; i < 2; i++) begin
            step();
            chk("stl_fpc",   F_PC,    32'h0000_3018);
            chk("stl_dpc",   D_PC,    32'h0000_3014);
            chk("stl_dinst", D_Instr, 32'hC0DE_3014);
        end
        stall = 1'b0; D_jSel = 2'b00;
        step();
        D_flush = 1'b0;
        chk("stl_rel_dinst", D_Instr, 32'h0);
        chk("stl_rel_dpc",   D_PC,    32'h0000_3018);
        chk("stl_rel_fpc",   F_PC,    32'h0000_301C);

        D_jSel = 2'b10; D_RD1 = 32'h0000_3400;
        step();
        chk("jr_fpc", F_PC, 32'h0000_3400);
        chk("jr_dpc", D_PC, 32'h0000_301C);

        D_RD1 = 32'h0000_3000;
        step();
        D_jSel = 2'b00; use_ovr = 1'b1; ovr_instr = 32'h0800_0D00;
        step();
        use_ovr = 1'b0;
        chk("j_dpc", D_PC, 32'h0000_3000);
        D_jSel = 2'b01;
        step();
        chk("j_fpc", F_PC, 32'h0000_3400);

        D_jSel = 2'b11; D_RD1 = 32'h0000_5000;
        step();
        chk("rsvd_fpc", F_PC, 32'h0000_3404);

        D_jSel = 2'b10; D_isBranch = 1'b1; D_RD1 = 32'h0000_3500;
        step();
        D_isBranch = 1'b0;
        chk("prio_fpc", F_PC, 32'h0000_3500);

        D_RD1 = 32'hFFFF_FFFC;
        step();
        D_jSel = 2'b00;
        step();
        chk("wrap_fpc", F_PC, 32'h0000_0000);

        // Reset mid-stall with a pending jr must fall back to RESET_PC.
        stall = 1'b1; D_jSel = 2'b10; D_RD1 = 32'h0000_3400;
        #2;
        reset = 1'b1;
        #1;
        chk("mrst_fpc",   F_PC,    32'h0000_3000);
        chk("mrst_dinst", D_Instr, 32'h0);
        chk("mrst_dpc",   D_PC,    32'h0);
        #1;
        reset = 1'b0; stall = 1'b0; D_jSel = 2'b00;
        step();
        chk("mrst_rel_fpc", F_PC, 32'h0000_3004);

`ifdef FETCH_ADDR_CHECK_EN
        D_jSel = 2'b10; D_RD1 = 32'h0000_3002;
        step();
        D_jSel = 2'b00;
        step();
        chk("exc_mis_flag",  {31'b0, D_excAdEL}, 32'h1);
        chk("exc_mis_dinst", D_Instr, 32'h0);
        D_jSel = 2'b10; D_RD1 = 32'h0000_7000;
        step();
        D_jSel = 2'b00;
        step();
        chk("exc_hi_flag", {31'b0, D_excAdEL}, 32'h1);
        D_jSel = 2'b10; D_RD1 = 32'h0000_6FFC;
        step();
        D_jSel = 2'b00;
        step();
        chk("exc_ok_flag",  {31'b0, D_excAdEL}, 32'h0);
        chk("exc_ok_dinst", D_Instr, 32'hC0DE_6FFC);
`endif

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_3000, meaning the first fetch address after reset.
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port stall  input  1  hazard-unit freeze of the PC and the F/D register.
REQ-005 SHALL have port D_isBranch  input  1  the comparator result for the D-stage branch (1 = taken).
REQ-006 SHALL have port D_flush  input  1  the comparator request to annul the delay-slot instruction.
REQ-007 SHALL have port D_jSel  input  2  jump kind of the D instruction: 00 none, 01 j/jal, 10 jr, 11 reserved (treated as 00).
REQ-008 SHALL have port D_RD1  input  32  forwarded rs value; this is the jr target.
REQ-009 SHALL have port F_Instr  input  32  instruction-memory read data for F_PC, combinational.
REQ-010 SHALL have port F_PC  output  32  current fetch address (PC register).
REQ-011 SHALL have port D_Instr  output  32  F/D register instruction.
REQ-012 SHALL have port D_PC  output  32  F/D register PC.

Function
REQ-013 SHALL compute next PC with priority jr > j > taken branch > sequential: D_RD1; {D_PC[31:28], D_Instr[25:0], 2'b00}; D_PC + 4 + (sign-extended D_Instr[15:0] << 2); F_PC + 4.
REQ-014 SHALL do all next-PC arithmetic modulo 2^32 (wrap-around, no saturation).
REQ-015 SHALL, when stall=0, load PC with the next PC and load F/D with {F_Instr, F_PC} each cycle.
REQ-016 SHALL, when stall=1, hold the PC, D_Instr and D_PC unchanged and ignore D_isBranch, D_flush and D_jSel that cycle.
REQ-017 SHALL, when stall=0 and D_flush=1, load D_Instr with 32'h0000_0000 (nop) and D_PC with F_PC, annulling the delay slot.
REQ-018 SHALL let stall win over D_flush when both are 1 (no annul; the decision is re-evaluated next unstalled cycle).
REQ-019 SHALL treat the redirect as one-delay-slot: the instruction at branch PC+4 always enters D unless annulled by REQ-017.
REQ-020 SHALL have zero-cycle redirect latency: a target chosen in cycle N is F_PC in cycle N+1.

Reset
REQ-021 SHALL, while reset=1, force F_PC=RESET_PC, D_Instr=0 and D_PC=0 immediately, independent of clk.
REQ-022 SHALL, on reset assertion mid-branch or mid-stall, discard any pending redirect; the first fetch after release is RESET_PC.

Configuration
REQ-023 SHALL, with FETCH_ADDR_CHECK_EN defined, add output D_excAdEL (1 bit) set when the latched PC has PC[1:0]!=0 or lies outside 32'h0000_3000..32'h0000_6FFC, and capture D_Instr=0 for that fetch.
REQ-024 SHALL, without FETCH_ADDR_CHECK_EN, omit D_excAdEL and perform no address checking.
REQ-025 SHALL reset D_excAdEL to 0 and apply the REQ-016/REQ-017 stall and annul rules to it (annul clears it).

Structure
REQ-026 SHALL place the D_jSel encodings, the nop constant and the check-range bounds in the shared include/package with the instruction-type macros.
REQ-027 SHALL put next-PC selection in one combinational sub-module named npc; the PC and F/D registers stay in fetch_unit.

Verification
REQ-028 SHALL cover reset: reset pulse mid-run -> F_PC=32'h3000, D_Instr=0, D_PC=0 without a clock edge; F_PC=32'h3004 one edge after release.
REQ-029 SHALL cover taken branch: D_PC=32'h3008, imm=16'hFFFE, D_isBranch=1 -> next F_PC=32'h3004; delay slot at 32'h300C reaches D.
REQ-030 SHALL cover annul: D_isBranch=0, D_flush=1 at F_PC=32'h3010 -> D_Instr=0, D_PC=32'h3010, F_PC=32'h3014.
REQ-031 SHALL cover stall+flush: stall=1, D_flush=1 for 2 cycles -> PC and F/D unchanged; on release with D_flush=1, REQ-017 applies.
REQ-032 SHALL cover jumps: D_jSel=10, D_RD1=32'h3400 -> F_PC=32'h3400; D_jSel=01, D_Instr[25:0]=26'h0000D00, D_PC=32'h3000 -> F_PC=32'h3400.
REQ-033 SHALL cover FETCH_ADDR_CHECK_EN: jr to 32'h3002 -> D_excAdEL=1, D_Instr=0; jr to 32'h7000 -> D_excAdEL=1; jr to 32'h6FFC -> D_excAdEL=0.
